// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the per-port clock-gate controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_REQ   = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int CG_WAKE_CYC_DEF = 4;

  // Output decode per state, packed as {clk_en, gate_req, clk_rdy}.
  function automatic logic [2:0] cg_outputs(cg_state_e s);
    case (s)
      CG_RUN:   return 3'b101;
      CG_REQ:   return 3'b111;
      CG_GATED: return 3'b010;
      default:  return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/clk_gate_chan.sv
// One port's gate FSM with a counter shared between idle detection and wake settling.
module clk_gate_chan
  import clk_gate_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = CG_WAKE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate_allow,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic             busy,
  input  logic             wake_req,
  input  logic             force_on,
  input  logic             gate_ack,
  output logic             clk_en,
  output logic             gate_req,
  output logic             clk_rdy,
  output cg_state_e        state
);

  localparam int WAKE_W = $clog2(WAKE_CYC + 1);
  localparam int CW     = (CNT_W > WAKE_W) ? CNT_W : WAKE_W;
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYC - 1);

  cg_state_e     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   thresh_ext;
  logic          idle;
  logic          reach;

  assign idle       = !busy && gate_allow && !force_on && (idle_thresh != '0);
  assign cnt_inc    = {1'b0, cnt_reg} + (CW+1)'(1);
  assign thresh_ext = (CW+1)'(idle_thresh);
  // >= so that lowering the threshold mid-count fires on the next idle cycle
  assign reach      = cnt_inc >= thresh_ext;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CG_RUN: begin
        if (!idle) begin
          cnt_next = '0;
        end else if (reach) begin
          state_next = CG_REQ;
          cnt_next   = '0;
        end else if (!(&cnt_reg)) begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
      CG_REQ: begin
        if (!idle) begin
          state_next = CG_RUN;
          cnt_next   = '0;
        end else if (gate_ack) begin
          state_next = CG_GATED;
        end
      end
      CG_GATED: begin
        if (wake_req || force_on || !gate_allow) begin
          state_next = CG_WAKE;
          cnt_next   = '0;
        end
      end
      default: begin
        if (cnt_reg == WAKE_LAST) begin
          state_next = CG_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
    endcase
  end

  // Outputs are registered from the next state so clk_en is a pure flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CG_RUN;
      cnt_reg   <= '0;
      clk_en    <= 1'b1;
      gate_req  <= 1'b0;
      clk_rdy   <= 1'b1;
    end else begin
      state_reg                     <= state_next;
      cnt_reg                       <= cnt_next;
      {clk_en, gate_req, clk_rdy}   <= cg_outputs(state_next);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-port clock-gate enable controller: one independent channel per gated clock port.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int CNT_W     = 8,
  parameter int WAKE_CYC  = CG_WAKE_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gate_allow,
  input  logic [CNT_W-1:0]       idle_thresh,
  input  logic [NUM_PORTS-1:0]   busy,
  input  logic [NUM_PORTS-1:0]   wake_req,
  input  logic [NUM_PORTS-1:0]   force_on,
  input  logic [NUM_PORTS-1:0]   gate_ack,
  output logic [NUM_PORTS-1:0]   clk_en,
  output logic [NUM_PORTS-1:0]   gate_req,
  output logic [NUM_PORTS-1:0]   clk_rdy,
  output logic [2*NUM_PORTS-1:0] state
);

  cg_state_e chan_state [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
      clk_gate_chan #(
        .CNT_W    (CNT_W),
        .WAKE_CYC (WAKE_CYC)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .gate_allow  (gate_allow),
        .idle_thresh (idle_thresh),
        .busy        (busy[gi]),
        .wake_req    (wake_req[gi]),
        .force_on    (force_on[gi]),
        .gate_ack    (gate_ack[gi]),
        .clk_en      (clk_en[gi]),
        .gate_req    (gate_req[gi]),
        .clk_rdy     (clk_rdy[gi]),
        .state       (chan_state[gi])
      );
      assign state[2*gi +: 2] = chan_state[gi];
    end
  endgenerate

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (8 ports, 8-bit threshold, 4-cycle wake).
module tb_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate_allow;
  logic [7:0]  idle_thresh;
  logic [7:0]  busy, wake_req, force_on, gate_ack;
  logic [7:0]  clk_en, gate_req, clk_rdy;
  logic [15:0] state;

  int errors = 0;
  int checks = 0;

  clk_gate_ctrl #(.NUM_PORTS(8), .CNT_W(8), .WAKE_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .gate_allow  (gate_allow),
    .idle_thresh (idle_thresh),
    .busy        (busy),
    .wake_req    (wake_req),
    .force_on    (force_on),
    .gate_ack    (gate_ack),
    .clk_en      (clk_en),
    .gate_req    (gate_req),
    .clk_rdy     (clk_rdy),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gate_allow = 1'b1; idle_thresh = 8'd5;
    busy = 8'hFF; wake_req = '0; force_on = '0; gate_ack = '0;
    step(2);
    checks++;
    if ({clk_en, gate_req, clk_rdy, state} !== {8'hFF, 8'h00, 8'hFF, 16'h0000}) begin
      errors++;
      $display("FAIL reset: en=%h req=%h rdy=%h st=%h, want en=ff req=00 rdy=ff st=0000",
               clk_en, gate_req, clk_rdy, state);
    end
    rst = 1'b0;
    step(1);
    $display("test_reset done");
  endtask

  task automatic test_gate_entry();
    busy = 8'hFE;
    step(4);
    checks++;
    if (gate_req[0] !== 1'b0) begin
      errors++;
      $display("FAIL entry_early: gate_req0=%b want 0 after 4 idle", gate_req[0]);
    end
    step(1);
    checks++;
    if (gate_req[0] !== 1'b1 || state[1:0] !== 2'd1) begin
      errors++;
      $display("FAIL entry_req: gate_req0=%b st0=%0d want 1/1 after 5 idle", gate_req[0], state[1:0]);
    end
    step(3);
    checks++;
    if (state[1:0] !== 2'd1 || clk_en[0] !== 1'b1) begin
      errors++;
      $display("FAIL entry_hold: st0=%0d en0=%b want 1/1 without ack", state[1:0], clk_en[0]);
    end
    gate_ack = 8'h01;
    step(1);
    gate_ack = 8'h00;
    checks++;
    if ({clk_en[0], gate_req[0], clk_rdy[0]} !== 3'b010 || state[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL entry_gated: en/req/rdy=%b st0=%0d want 010/2",
               {clk_en[0], gate_req[0], clk_rdy[0]}, state[1:0]);
    end
    busy = 8'hFF; gate_ack = 8'h01;
    step(2);
    gate_ack = 8'h00; busy = 8'hFE;
    checks++;
    if (state[1:0] !== 2'd2 || clk_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL gated_ignore_busy: st0=%0d en0=%b want 2/0", state[1:0], clk_en[0]);
    end
    $display("test_gate_entry done");
  endtask

  task automatic test_wake();
    wake_req = 8'h01;
    step(1);
    wake_req = 8'h00;
    busy = 8'hFF;
    checks++;
    if ({clk_en[0], gate_req[0], clk_rdy[0]} !== 3'b100 || state[1:0] !== 2'd3) begin
      errors++;
      $display("FAIL wake_enter: en/req/rdy=%b st0=%0d want 100/3",
               {clk_en[0], gate_req[0], clk_rdy[0]}, state[1:0]);
    end
    wake_req = 8'h01;
    step(3);
    wake_req = 8'h00;
    checks++;
    if (clk_rdy[0] !== 1'b0 || state[1:0] !== 2'd3) begin
      errors++;
      $display("FAIL wake_settle: rdy0=%b st0=%0d want 0/3 at k+3", clk_rdy[0], state[1:0]);
    end
    step(1);
    checks++;
    if ({clk_en[0], gate_req[0], clk_rdy[0]} !== 3'b101 || state[1:0] !== 2'd0) begin
      errors++;
      $display("FAIL wake_done: en/req/rdy=%b st0=%0d want 101/0 at k+4",
               {clk_en[0], gate_req[0], clk_rdy[0]}, state[1:0]);
    end
    $display("test_wake done");
  endtask

  task automatic test_req_abort();
    busy = 8'hFD;
    step(5);
    checks++;
    if (state[3:2] !== 2'd1) begin
      errors++;
      $display("FAIL abort_req: st1=%0d want 1", state[3:2]);
    end
    busy = 8'hFF; gate_ack = 8'h02;
    step(1);
    gate_ack = 8'h00; busy = 8'hFD;
    checks++;
    if ({clk_en[1], gate_req[1], clk_rdy[1]} !== 3'b101 || state[3:2] !== 2'd0) begin
      errors++;
      $display("FAIL abort_run: en/req/rdy=%b st1=%0d want 101/0",
               {clk_en[1], gate_req[1], clk_rdy[1]}, state[3:2]);
    end
    step(4);
    checks++;
    if (gate_req[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_recount_early: req1=%b want 0 after 4 idle", gate_req[1]);
    end
    step(1);
    checks++;
    if (gate_req[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_recount: req1=%b want 1 after 5 idle", gate_req[1]);
    end
    busy = 8'hFF;
    step(1);
    $display("test_req_abort done");
  endtask

  task automatic test_no_gate();
    logic left;
    for (int mode = 0; mode < 3; mode++) begin
      idle_thresh = (mode == 0) ? 8'd0 : 8'd5;
      force_on    = (mode == 1) ? 8'h08 : 8'h00;
      gate_allow  = (mode == 2) ? 1'b0 : 1'b1;
      busy = 8'hF7;
      left = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        step(1);
        if (state[7:6] != 2'd0 || clk_en[3] != 1'b1) left = 1'b1;
      end
      checks++;
      if (left !== 1'b0) begin
        errors++;
        $display("FAIL no_gate mode%0d: port3 left RUN=%b want 0", mode, left);
      end
      busy = 8'hFF;
    end
    force_on = 8'h00; gate_allow = 1'b1; idle_thresh = 8'd5;
    step(1);
    $display("test_no_gate done");
  endtask

  task automatic test_thresh_change();
    idle_thresh = 8'd10; busy = 8'hEF;
    step(3);
    idle_thresh = 8'd2;
    step(1);
    checks++;
    if (state[9:8] !== 2'd1) begin
      errors++;
      $display("FAIL thresh_lower: st4=%0d want 1", state[9:8]);
    end
    busy = 8'hFF; idle_thresh = 8'd5;
    step(1);
    $display("test_thresh_change done");
  endtask

  task automatic test_all_ports();
    idle_thresh = 8'd2; busy = 8'h00; gate_ack = 8'hFF;
    step(4);
    gate_ack = 8'h00;
    checks++;
    if (state !== 16'hAAAA || clk_en !== 8'h00 || gate_req !== 8'hFF) begin
      errors++;
      $display("FAIL all_gated: st=%h en=%h req=%h want aaaa/00/ff", state, clk_en, gate_req);
    end
    gate_allow = 1'b0;
    step(1);
    checks++;
    if (state !== 16'hFFFF || clk_en !== 8'hFF || gate_req !== 8'h00) begin
      errors++;
      $display("FAIL all_wake: st=%h en=%h req=%h want ffff/ff/00", state, clk_en, gate_req);
    end
    step(3);
    checks++;
    if (clk_rdy !== 8'h00) begin
      errors++;
      $display("FAIL all_settle: rdy=%h want 00", clk_rdy);
    end
    step(1);
    checks++;
    if (state !== 16'h0000 || clk_rdy !== 8'hFF) begin
      errors++;
      $display("FAIL all_run: st=%h rdy=%h want 0000/ff", state, clk_rdy);
    end
    gate_allow = 1'b1; busy = 8'hFF; idle_thresh = 8'd5;
    step(1);
    $display("test_all_ports done");
  endtask

  task automatic test_reset_mid();
    idle_thresh = 8'd2; busy = 8'hFC; gate_ack = 8'h03;
    step(3);
    gate_ack = 8'h00; wake_req = 8'h02;
    step(1);
    wake_req = 8'h00;
    checks++;
    if (state[3:0] !== 4'hE) begin
      errors++;
      $display("FAIL mid_setup: st[3:0]=%h want e", state[3:0]);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (clk_en !== 8'hFF || clk_rdy !== 8'hFF || state !== 16'h0000 || gate_req !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: en=%h rdy=%h st=%h req=%h want ff/ff/0000/00",
               clk_en, clk_rdy, state, gate_req);
    end
    busy = 8'hFF;
    step(1);
    rst = 1'b0;
    step(1);
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_gate_entry();
    test_wake();
    test_req_abort();
    test_no_gate();
    test_thresh_change();
    test_all_ports();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
